// File: rtl/gray_counter_conv.sv
`default_nettype none
// ============================================================================
// Module   : gray_counter_conv
// Brief    : Up/down binary+Gray counter with load, plus an independent
//            valid/ready binary<->Gray conversion channel.
// Revision : 1.0
// ============================================================================
module gray_counter_conv #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap,
   input  logic             conv_mode,
   input  logic             conv_in_valid,
   input  logic [WIDTH-1:0] conv_in_data,
   output logic             conv_in_ready,
   output logic             conv_out_valid,
   output logic [WIDTH-1:0] conv_out_data,
   input  logic             conv_out_ready
);

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   localparam logic [WIDTH-1:0] c_reset_gray = RESET_VAL ^ (RESET_VAL >> 1);
   localparam logic [WIDTH-1:0] c_all_ones   = '1;
   localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------- counter
   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;
   logic [WIDTH-1:0] w_bin_next;
   logic             w_wrap_next;

   // Next value computed once so both registers load from the same source;
   // gray_out is never re-derived from the bin_out register.
   always_comb begin
      w_bin_next  = r_bin;
      w_wrap_next = 1'b0;
      if (load) begin
         w_bin_next = load_val;
      end else if (en) begin
         if (up) begin
            w_bin_next  = r_bin + c_one;
            w_wrap_next = (r_bin == c_all_ones);
         end else begin
            w_bin_next  = r_bin - c_one;
            w_wrap_next = (r_bin == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= RESET_VAL;
         r_gray <= c_reset_gray;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= bin2gray(w_bin_next);
         r_wrap <= w_wrap_next;
      end
   end

   assign bin_out  = r_bin;
   assign gray_out = r_gray;
   assign wrap     = r_wrap;

   // -------------------------------------------------------------- converter
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             w_accept;

   // Only conv_out_ready reaches conv_in_ready combinationally.
   assign conv_in_ready = !r_out_valid || conv_out_ready;
   assign w_accept      = conv_in_valid && conv_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= conv_mode ? gray2bin(conv_in_data) : bin2gray(conv_in_data);
      end else if (conv_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign conv_out_valid = r_out_valid;
   assign conv_out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_counter_conv
// Brief    : Directed self-checking bench for gray_counter_conv (WIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_gray_counter_conv;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] bin_out;
   logic [3:0] gray_out;
   logic       wrap;
   logic       conv_mode;
   logic       conv_in_valid;
   logic [3:0] conv_in_data;
   logic       conv_in_ready;
   logic       conv_out_valid;
   logic [3:0] conv_out_data;
   logic       conv_out_ready;

   int n_vec;
   int n_err;
   logic [3:0] exp_q[$];

   gray_counter_conv #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .up             (up),
      .load           (load),
      .load_val       (load_val),
      .bin_out        (bin_out),
      .gray_out       (gray_out),
      .wrap           (wrap),
      .conv_mode      (conv_mode),
      .conv_in_valid  (conv_in_valid),
      .conv_in_data   (conv_in_data),
      .conv_in_ready  (conv_in_ready),
      .conv_out_valid (conv_out_valid),
      .conv_out_data  (conv_out_data),
      .conv_out_ready (conv_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare held result against the scoreboard head.
   task automatic check_out(input string tag);
      check({tag, "_valid"}, {31'd0, conv_out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         check({tag, "_data"}, {28'd0, conv_out_data}, {28'd0, exp_q[0]});
      end
   endtask

   logic [3:0] c_gray_seq [17];
   logic [3:0] prev_gray;

   initial begin
      c_gray_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                     4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'h0;
      conv_mode = 1'b0; conv_in_valid = 1'b0; conv_in_data = 4'h0;
      conv_out_ready = 1'b1;

      // Reset takes effect before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_bin",      {28'd0, bin_out},  32'h0);
      check("rst_gray",     {28'd0, gray_out}, 32'h0);
      check("rst_wrap",     {31'd0, wrap},     32'd0);
      check("rst_oval",     {31'd0, conv_out_valid}, 32'd0);
      check("rst_odata",    {28'd0, conv_out_data},  32'h0);
      check("rst_in_ready", {31'd0, conv_in_ready},  32'd1);
      @(negedge clk) rst_n = 1'b1;

      // Count up through a full wrap.
      en = 1'b1; up = 1'b1;
      check("up_gray_0", {28'd0, gray_out}, {28'd0, c_gray_seq[0]});
      prev_gray = gray_out;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("up_bin_%0d", k),  {28'd0, bin_out},  k % 16);
         check($sformatf("up_gray_%0d", k), {28'd0, gray_out}, {28'd0, c_gray_seq[k]});
         check($sformatf("up_wrap_%0d", k), {31'd0, wrap},     (k == 16) ? 32'd1 : 32'd0);
         check($sformatf("up_onebit_%0d", k), $countones(prev_gray ^ gray_out), 32'd1);
         prev_gray = gray_out;
      end

      // Count down from 0.
      up = 1'b0;
      tick();
      check("dn_bin_0",  {28'd0, bin_out},  32'hF);
      check("dn_gray_0", {28'd0, gray_out}, 32'h8);
      check("dn_wrap_0", {31'd0, wrap},     32'd1);
      tick();
      check("dn_bin_1",  {28'd0, bin_out},  32'hE);
      check("dn_gray_1", {28'd0, gray_out}, 32'h9);
      check("dn_wrap_1", {31'd0, wrap},     32'd0);

      // Load beats en/up.
      load = 1'b1; load_val = 4'b1001;
      tick();
      check("ld_bin",  {28'd0, bin_out},  32'h9);
      check("ld_gray", {28'd0, gray_out}, 32'hD);
      check("ld_wrap", {31'd0, wrap},     32'd0);
      load = 1'b0; up = 1'b1;
      tick();
      check("ld_next_bin",  {28'd0, bin_out},  32'hA);
      check("ld_next_gray", {28'd0, gray_out}, 32'hF);
      en = 1'b0;
      tick();
      check("hold_bin", {28'd0, bin_out}, 32'hA);

      // Back-to-back conversions, ready held high.
      conv_out_ready = 1'b1;
      conv_in_valid = 1'b1; conv_mode = 1'b0; conv_in_data = 4'b0110;
      exp_q.push_back(4'b0101);
      tick();
      check_out("cv_b2g_0110");
      conv_mode = 1'b1; conv_in_data = 4'b1101;
      exp_q.push_back(4'b1001);
      tick();
      void'(exp_q.pop_front());
      check_out("cv_g2b_1101");
      conv_mode = 1'b1; conv_in_data = 4'b1000;
      exp_q.push_back(4'b1111);
      tick();
      void'(exp_q.pop_front());
      check_out("cv_g2b_1000");
      conv_in_valid = 1'b0;
      tick();
      void'(exp_q.pop_front());
      check("cv_drain_valid", {31'd0, conv_out_valid}, 32'd0);

      // Backpressure: one result held while the next beat waits.
      conv_out_ready = 1'b0;
      conv_in_valid = 1'b1; conv_mode = 1'b0; conv_in_data = 4'b0011;
      exp_q.push_back(4'b0010);
      tick();
      check_out("bp_first");
      conv_mode = 1'b1; conv_in_data = 4'b0110;
      #1;
      check("bp_in_ready_low", {31'd0, conv_in_ready}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_out($sformatf("bp_hold_%0d", k));
         check($sformatf("bp_in_ready_%0d", k), {31'd0, conv_in_ready}, 32'd0);
      end
      conv_out_ready = 1'b1;
      #1;
      check("bp_in_ready_comb", {31'd0, conv_in_ready}, 32'd1);
      exp_q.push_back(4'b0100);
      tick();
      void'(exp_q.pop_front());
      check_out("bp_no_bubble");

      // Stall again, then reset mid-stall drops the pending result.
      conv_out_ready = 1'b0;
      conv_in_valid = 1'b0;
      tick();
      check_out("bp_stall2");
      #3 rst_n = 1'b0;
      #1;
      check("rst_stall_oval",     {31'd0, conv_out_valid}, 32'd0);
      check("rst_stall_odata",    {28'd0, conv_out_data},  32'h0);
      check("rst_stall_in_ready", {31'd0, conv_in_ready},  32'd1);
      check("rst_stall_bin",      {28'd0, bin_out},        32'h0);
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("post_rst_oval", {31'd0, conv_out_valid}, 32'd0);
      check("post_rst_bin",  {28'd0, bin_out},        32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
